// File: rtl/frame_triple_buffer_sched_pkg.sv
// Shared types and constants for the triple-buffered frame scheduler.
// Buffer indices are 2-bit; the reset assignment puts the writer on 0 and the display on 2.
package frame_triple_buffer_sched_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam int NBUF = 3;

  localparam buf_idx_t RST_W_IDX = 2'd0;
  localparam buf_idx_t RST_R_IDX = 2'd1;
  localparam buf_idx_t RST_D_IDX = 2'd2;

endpackage

// File: rtl/frame_triple_buffer_sched_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/frame_triple_buffer_sched.sv
// Triple-buffer scheduler: rotates writer/ready/display buffer indices on write completion
// and reader frame starts, and counts dropped and repeated frames.
module frame_triple_buffer_sched
  import frame_triple_buffer_sched_pkg::*;
#(
  parameter int BUFSIZE = 76800,
  parameter int AW      = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vblank_in,
  input  logic          rd_frame_start,
  output logic [1:0]    wr_buf,
  output logic [1:0]    rd_buf,
  output logic [AW-1:0] wr_base,
  output logic [AW-1:0] rd_base,
  output logic          rd_new,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   repeat_cnt
);

  if (longint'(NBUF) * longint'(BUFSIZE) > (longint'(1) << AW)) begin : g_size_check
    $error("frame_triple_buffer_sched: 3*BUFSIZE does not fit in 2**AW");
  end

  localparam logic [AW-1:0] BASE0 = '0;
  localparam logic [AW-1:0] BASE1 = AW'(BUFSIZE);
  localparam logic [AW-1:0] BASE2 = AW'(2 * BUFSIZE);

  // Base addresses come from a three-way constant select, so no multiplier is built.
  function automatic logic [AW-1:0] base_of(input buf_idx_t idx);
    case (idx)
      2'd0:    base_of = BASE0;
      2'd1:    base_of = BASE1;
      default: base_of = BASE2;
    endcase
  endfunction

  buf_idx_t      w_q, w_d;
  buf_idx_t      r_q, r_d;
  buf_idx_t      d_q, d_d;
  logic          rv_q, rv_d;
  logic          vblank_q;
  logic          rd_new_q, rd_new_d;
  logic [AW-1:0] wr_base_q;
  logic [AW-1:0] rd_base_q;
  logic          wc;
  logic          drop_inc;
  logic          repeat_inc;

  assign wc         = vblank_in & ~vblank_q;
  assign drop_inc   = wc & rv_q;
  assign repeat_inc = rd_frame_start & ~wc & ~rv_q;

  // A simultaneous completion and start hands the just-written frame straight to the display.
  always_comb begin
    w_d      = w_q;
    r_d      = r_q;
    d_d      = d_q;
    rv_d     = rv_q;
    rd_new_d = 1'b0;
    if (wc && rd_frame_start) begin
      d_d      = w_q;
      w_d      = d_q;
      rv_d     = 1'b0;
      rd_new_d = 1'b1;
    end else if (wc) begin
      r_d  = w_q;
      w_d  = r_q;
      rv_d = 1'b1;
    end else if (rd_frame_start && rv_q) begin
      d_d      = r_q;
      r_d      = d_q;
      rv_d     = 1'b0;
      rd_new_d = 1'b1;
    end
  end

  // Edge history resets high so a vblank already asserted at release is not a completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q       <= RST_W_IDX;
      r_q       <= RST_R_IDX;
      d_q       <= RST_D_IDX;
      rv_q      <= 1'b0;
      vblank_q  <= 1'b1;
      rd_new_q  <= 1'b0;
      wr_base_q <= base_of(RST_W_IDX);
      rd_base_q <= base_of(RST_D_IDX);
    end else begin
      w_q       <= w_d;
      r_q       <= r_d;
      d_q       <= d_d;
      rv_q      <= rv_d;
      vblank_q  <= vblank_in;
      rd_new_q  <= rd_new_d;
      wr_base_q <= base_of(w_d);
      rd_base_q <= base_of(d_d);
    end
  end

  sat_counter16 u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (drop_inc),
    .count_o (drop_cnt)
  );

  sat_counter16 u_repeat_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (repeat_inc),
    .count_o (repeat_cnt)
  );

  assign wr_buf  = w_q;
  assign rd_buf  = d_q;
  assign wr_base = wr_base_q;
  assign rd_base = rd_base_q;
  assign rd_new  = rd_new_q;

endmodule
